// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache: 8 lines x 16 bytes.
// Word hits complete with no added latency; misses run an optional block
// write-back followed by a block fill over the memory busywait handshake.
module dcache_controller (
   input  logic         clock,
   input  logic         reset,
   input  logic         read,
   input  logic         write,
   input  logic [31:0]  address,
   input  logic [31:0]  writedata,
   output logic [31:0]  readdata,
   output logic         busywait,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_address,
   output logic [127:0] mem_writedata,
   input  logic [127:0] mem_readdata,
   input  logic         mem_busywait
);

   typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

   state_t       state;
   logic [7:0]   valid;
   logic [7:0]   dirty;
   logic [24:0]  tag_array  [0:7];
   logic [127:0] data_array [0:7];

   // Line and tag of the miss being serviced, captured when the miss is
   // detected so the transfer completes even if the request drops mid-miss.
   logic [24:0]  miss_tag;
   logic [2:0]   miss_index;

   logic [24:0]  tag;
   logic [2:0]   index;
   logic [1:0]   word;
   logic         is_read;
   logic         is_write;
   logic         access;
   logic         hit;
   logic         write_hit;
   logic         fill_done;
   logic         unused_bits;

   assign tag         = address[31:7];
   assign index       = address[6:4];
   assign word        = address[3:2];
   assign unused_bits = ^address[1:0];

   // Simultaneous read and write is treated as no access at all.
   assign is_read   = read & ~write;
   assign is_write  = write & ~read;
   assign access    = is_read | is_write;
   assign hit       = valid[index] && (tag_array[index] == tag);
   assign write_hit = (state == IDLE) && is_write && hit;
   assign fill_done = (state == MEM_READ) && !mem_busywait;

   // Controller FSM plus valid/dirty bits; reset discards all lines.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         valid      <= '0;
         dirty      <= '0;
         miss_tag   <= '0;
         miss_index <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (write_hit) begin
                  dirty[index] <= 1'b1;
               end else if (access && !hit) begin
                  miss_tag   <= tag;
                  miss_index <= index;
                  if (valid[index] && dirty[index])
                     state <= WRITE_BACK;
                  else
                     state <= MEM_READ;
               end
            end
            WRITE_BACK: begin
               if (!mem_busywait)
                  state <= MEM_READ;
            end
            MEM_READ: begin
               if (!mem_busywait) begin
                  valid[miss_index] <= 1'b1;
                  dirty[miss_index] <= 1'b0;
                  state             <= UPDATE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Tag and data storage; deliberately not cleared by reset.
   always_ff @(posedge clock) begin
      if (write_hit)
         data_array[index][{word, 5'b00000} +: 32] <= writedata;
      if (fill_done) begin
         data_array[miss_index] <= mem_readdata;
         tag_array[miss_index]  <= miss_tag;
      end
   end

   // Memory request decode: strobes depend on state only.
   always_comb begin
      mem_read      = (state == MEM_READ);
      mem_write     = (state == WRITE_BACK);
      mem_address   = '0;
      mem_writedata = '0;
      if (state == WRITE_BACK) begin
         mem_address   = {tag_array[miss_index], miss_index};
         mem_writedata = data_array[miss_index];
      end else if (state == MEM_READ) begin
         mem_address   = {miss_tag, miss_index};
      end
   end

   // CPU side: hit data and stall, both forced quiet while reset is held.
   always_comb begin
      readdata = 32'h0;
      if ((state == IDLE) && is_read && hit)
         readdata = data_array[index][{word, 5'b00000} +: 32];
      busywait = !reset && (((state == IDLE) && access && !hit) || (state != IDLE));
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a fixed-latency block memory model.
module tb_dcache_controller;

   localparam int LAT = 3;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         read = 1'b0;
   logic         write = 1'b0;
   logic [31:0]  address = '0;
   logic [31:0]  writedata = '0;
   logic [31:0]  readdata;
   logic         busywait;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_address;
   logic [127:0] mem_writedata;
   logic [127:0] mem_readdata;
   logic         mem_busywait;

   int checks = 0;
   int failures = 0;

   dcache_controller dut (
      .clock(clock), .reset(reset), .read(read), .write(write),
      .address(address), .writedata(writedata), .readdata(readdata),
      .busywait(busywait), .mem_read(mem_read), .mem_write(mem_write),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   always #5 clock = ~clock;

   // Memory model: busy for LAT cycles of each request, then ready for one.
   int cnt = 0;
   assign mem_busywait = (mem_read || mem_write) && (cnt < LAT);
   // Fill word w of block b is {w, 2'b10, b}.
   assign mem_readdata = {2'd3, 2'b10, mem_address, 2'd2, 2'b10, mem_address,
                          2'd1, 2'b10, mem_address, 2'd0, 2'b10, mem_address};

   // Transfer log: completed requests in order.
   int           log_n = 0;
   logic         log_wr   [0:15];
   logic [27:0]  log_addr [0:15];
   logic [127:0] log_data [0:15];
   logic         both_seen = 1'b0;

   always @(posedge clock) begin
      if (!(mem_read || mem_write) || !mem_busywait)
         cnt <= 0;
      else
         cnt <= cnt + 1;
      if ((mem_read || mem_write) && !mem_busywait && log_n < 16) begin
         log_wr[log_n]   <= mem_write;
         log_addr[log_n] <= mem_address;
         log_data[log_n] <= mem_writedata;
         log_n           <= log_n + 1;
      end
      if (mem_read && mem_write)
         both_seen <= 1'b1;
   end

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // Count stalled negedges until busywait drops (bounded).
   task automatic wait_ready(output int stalls);
      stalls = 0;
      forever begin
         @(negedge clock);
         if (!busywait) break;
         stalls++;
         if (stalls > 200) begin
            chk("timeout", 1'b1, 1'b0);
            break;
         end
      end
   endtask

   // Full access from posedge+1: returns stall count and the data seen when ready.
   task automatic do_access(input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int stalls, output logic [31:0] rd);
      read = r; write = w; address = a; writedata = d;
      wait_ready(stalls);
      rd = readdata;
      $display("access r=%0b w=%0b addr=%h wdata=%h stalls=%0d readdata=%h", r, w, a, d, stalls, rd);
      @(posedge clock); #1;
      read = 1'b0; write = 1'b0;
   endtask

   initial begin
      int st;
      logic [31:0] rd;

      // Reset state
      repeat (2) @(negedge clock);
      chk("rst_busywait", busywait, 1'b0);
      chk("rst_mem_read", mem_read, 1'b0);
      chk("rst_mem_write", mem_write, 1'b0);
      chk("rst_readdata", readdata, 32'h0);
      reset = 1'b0;
      @(posedge clock); #1;

      // 1: clean read miss at 0x40
      read = 1'b1; address = 32'h0000_0040;
      @(negedge clock);
      chk("t1_busy_detect", busywait, 1'b1);
      chk("t1_no_req_detect", mem_read, 1'b0);
      @(negedge clock);
      chk("t1_mem_read", mem_read, 1'b1);
      chk("t1_mem_addr", mem_address, 28'h0000004);
      chk("t1_no_mem_write", mem_write, 1'b0);
      wait_ready(st);
      chk("t1_stalls", st + 2, 6);
      chk("t1_readdata", readdata, 32'h2000_0004);
      $display("access read addr=00000040 stalls=%0d readdata=%h", st + 2, readdata);
      @(posedge clock); #1;
      read = 1'b0;
      chk("t1_log_n", log_n, 1);

      // 2: write hit, then read hits
      do_access(1'b0, 1'b1, 32'h0000_0044, 32'hDEADBEEF, st, rd);
      chk("t2_write_stalls", st, 0);
      chk("t2_write_readdata", rd, 32'h0);
      do_access(1'b1, 1'b0, 32'h0000_0044, 32'h0, st, rd);
      chk("t2_read_stalls", st, 0);
      chk("t2_read_data", rd, 32'hDEADBEEF);
      do_access(1'b1, 1'b0, 32'h0000_0048, 32'h0, st, rd);
      chk("t2_read_w2", rd, 32'hA000_0004);
      chk("t2_no_traffic", log_n, 1);

      // 3: dirty miss at 0x440 -> write-back then fill
      read = 1'b1; address = 32'h0000_0440;
      @(negedge clock);
      @(negedge clock);
      chk("t3_wb_first", {mem_write, mem_read}, 2'b10);
      @(posedge clock); #1;
      read = 1'b0;
      do_access(1'b1, 1'b0, 32'h0000_0440, 32'h0, st, rd);
      chk("t3_stalls", st + 2, 10);
      chk("t3_readdata", rd, 32'h2000_0044);
      chk("t3_log_n", log_n, 3);
      chk("t3_wb_kind", log_wr[1], 1'b1);
      chk("t3_wb_addr", log_addr[1], 28'h0000004);
      chk("t3_wb_word1", log_data[1][63:32], 32'hDEADBEEF);
      chk("t3_wb_word0", log_data[1][31:0], 32'h2000_0004);
      chk("t3_rd_kind", log_wr[2], 1'b0);
      chk("t3_rd_addr", log_addr[2], 28'h0000044);

      // 4: clean miss at 0x840 -> fill only
      do_access(1'b1, 1'b0, 32'h0000_0840, 32'h0, st, rd);
      chk("t4_stalls", st, 6);
      chk("t4_readdata", rd, 32'h2000_0084);
      chk("t4_log_n", log_n, 4);
      chk("t4_rd_kind", log_wr[3], 1'b0);
      chk("t4_rd_addr", log_addr[3], 28'h0000084);

      // 5: reset during MEM_READ
      read = 1'b1; address = 32'h0000_0040;
      @(negedge clock);
      @(negedge clock);
      chk("t5_in_mem_read", mem_read, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_mem_read", mem_read, 1'b0);
      chk("t5_rst_busywait", busywait, 1'b0);
      chk("t5_rst_mem_write", mem_write, 1'b0);
      chk("t5_rst_readdata", readdata, 32'h0);
      read = 1'b0;
      @(posedge clock); #3;
      reset = 1'b0;
      @(posedge clock); #1;
      do_access(1'b1, 1'b0, 32'h0000_0440, 32'h0, st, rd);
      chk("t5_remiss_stalls", st, 6);
      chk("t5_remiss_data", rd, 32'h2000_0044);
      chk("t5_log_n", log_n, 5);
      chk("t5_rd_kind", log_wr[4], 1'b0);

      // 6: read and write together are ignored
      do_access(1'b1, 1'b1, 32'h0000_0040, 32'h1111_1111, st, rd);
      chk("t6a_stalls", st, 0);
      chk("t6a_readdata", rd, 32'h0);
      do_access(1'b1, 1'b1, 32'h0000_0440, 32'h1234_5678, st, rd);
      chk("t6b_stalls", st, 0);
      chk("t6b_readdata", rd, 32'h0);
      do_access(1'b1, 1'b0, 32'h0000_0440, 32'h0, st, rd);
      chk("t6_unchanged", rd, 32'h2000_0044);
      chk("t6_no_traffic", log_n, 5);
      chk("never_both", both_seen, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
